// File: rtl/mem_access_unit_if.sv
// Core request/response channel and word-addressed ROM/RAM bus for mem_access_unit.
// Also defines the `MEM_ROM / `MEM_RAM space selectors shared with the memory block.
`ifndef MEM_ROM
`define MEM_ROM 1'b0
`endif
`ifndef MEM_RAM
`define MEM_RAM 1'b1
`endif

interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_type;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_input_data;
   logic        mem_write;
   logic        mem_read;
   logic        mem_type;
   logic [31:0] mem_output_data;

   modport master (
      input  req_valid, req_write, req_type, req_addr, req_size, req_unsigned, req_wdata,
             mem_output_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_input_data, mem_write, mem_read, mem_type
   );

   modport slave (
      output req_valid, req_write, req_type, req_addr, req_size, req_unsigned, req_wdata,
             mem_output_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_address, mem_input_data, mem_write, mem_read, mem_type
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the word-addressed ROM/RAM; sub-word stores are read-modify-write.
// Define MAU_ROM_WRITE_PROTECT_EN to reject every store aimed at the ROM space.
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 64
) (
   input logic               clock,
   input logic               reset,
   mem_access_unit_if.master bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_READ     = 3'd1;
   localparam logic [2:0] S_RMW_READ = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

`ifdef MAU_ROM_WRITE_PROTECT_EN
   localparam bit ROM_PROTECT = 1'b1;
`else
   localparam bit ROM_PROTECT = 1'b0;
`endif

   logic [2:0]  state_q, state_d;
   logic        write_q, write_d;
   logic        type_q, type_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] data_q, data_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        bad_size, misaligned, out_of_range, protected_store, req_err;
   logic        mem_active;

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [31:0] shifted;
      logic [31:0] res;
      res = word;
      case (size)
         2'b00: begin
            shifted = word >> {off, 3'b000};
            res = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            shifted = word >> {off[1], 4'b0000};
            res = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         end
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
      logic [31:0] lane_mask;
      logic [4:0]  sh;
      if (size == 2'b00) begin
         sh        = {off, 3'b000};
         lane_mask = 32'h0000_00FF << sh;
      end else begin
         sh        = {off[1], 4'b0000};
         lane_mask = 32'h0000_FFFF << sh;
      end
      return (old_word & ~lane_mask) | ((wdata << sh) & lane_mask);
   endfunction

   always_comb begin
      bad_size        = (bus.req_size == 2'b11);
      misaligned      = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      out_of_range    = (32'(bus.req_addr[31:2]) >= MEM_WORDS);
      protected_store = ROM_PROTECT && bus.req_write && (bus.req_type == `MEM_ROM);
      req_err         = bad_size || misaligned || out_of_range || protected_store;
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      type_d  = type_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               type_d  = bus.req_type;
               addr_d  = bus.req_addr;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               data_d  = bus.req_wdata;
               rdata_d = '0;
               err_d   = req_err;
               if (req_err)
                  state_d = S_RESP;
               else if (!bus.req_write)
                  state_d = S_READ;
               else if (bus.req_size == 2'b10)
                  state_d = S_WRITE;
               else
                  state_d = S_RMW_READ;
            end
         end
         S_READ: begin
            // Read data settled at the negedge inside this cycle; capture it on the closing edge.
            rdata_d = load_extend(bus.mem_output_data, addr_q[1:0], size_q, uns_q);
            state_d = S_RESP;
         end
         S_RMW_READ: begin
            data_d  = merge_store(bus.mem_output_data, data_q, addr_q[1:0], size_q);
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         write_q <= 1'b0;
         type_q  <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Strobes and bus fields come from state alone, so an async reset drops them immediately.
   assign mem_active         = (state_q == S_READ) || (state_q == S_RMW_READ) || (state_q == S_WRITE);
   assign bus.req_ready      = (state_q == S_IDLE);
   assign bus.resp_valid     = (state_q == S_RESP);
   assign bus.resp_rdata     = (state_q == S_RESP && !write_q) ? rdata_q : '0;
   assign bus.resp_error     = (state_q == S_RESP) ? err_q : 1'b0;
   assign bus.mem_read       = (state_q == S_READ) || (state_q == S_RMW_READ);
   assign bus.mem_write      = (state_q == S_WRITE);
   assign bus.mem_address    = mem_active ? {2'b00, addr_q[31:2]} : '0;
   assign bus.mem_input_data = (state_q == S_WRITE) ? data_q : '0;
   assign bus.mem_type       = mem_active ? type_q : 1'b0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator/master side of the word-addressed ROM/RAM memory interface.
- Accepts byte-addressed load/store requests from the core (byte, half, word; signed or unsigned loads) and sequences them as single-cycle mem_read/mem_write strobes.
- Performs sub-word stores as read-modify-write.
- Returns one response per request; sits between the core's execute/MEM stage and the memory block.

Parameters:
- MEM_WORDS, 64: words per memory space (ROM and RAM each). Word index >= MEM_WORDS is out of range.

Ports:
- clock  input  1  system clock; memory writes on posedge, memory read data updates on negedge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present; held by core until accepted
- req_ready  output  1  unit idle, request accepted on posedge when req_valid=1
- req_write  input  1  1=store, 0=load
- req_type  input  1  target space, `MEM_ROM or `MEM_RAM
- req_addr  input  32  byte address
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads when 1
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned, out of range, illegal size, or protected store (see feature)
- mem_address  output  32  word index = req_addr[31:2]
- mem_input_data  output  32  write data to memory
- mem_write  output  1  write strobe
- mem_read  output  1  read strobe
- mem_type  output  1  `MEM_ROM / `MEM_RAM
- mem_output_data  input  32  read data from memory

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0.
  - mem_read=0; mem_write=0; mem_address=0; mem_input_data=0; mem_type=0.
- States: IDLE, READ, RMW_READ, WRITE, RESP. Memory strobes are decoded from state only (Moore), stable across the whole cycle including the negedge.
- IDLE:
  - req_ready=1. On posedge with req_valid, latch all req_* fields.
  - Illegal size, misaligned (half with addr[0]=1; word with addr[1:0]!=0), or word index >= MEM_WORDS -> RESP with error=1. No memory access.
  - Load -> READ. Word store -> WRITE. Byte/half store -> RMW_READ.
- READ: mem_read=1 for exactly one cycle. Memory updates data at the negedge; unit captures mem_output_data at the ending posedge -> RESP.
- RMW_READ: mem_read=1 for one cycle. On capture, merge store data into the read word -> WRITE.
- WRITE: mem_write=1 and mem_input_data=merged/full word for one cycle; memory writes at the ending posedge -> RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata/resp_error are valid only while resp_valid=1 and are 0 otherwise.
- Byte lanes are little-endian: byte k = bits [8k+7:8k]; half selected by addr[1].
- Loads extract the lane, then sign-extend (req_unsigned=0) or zero-extend. Word loads pass through.
- Latency from acceptance edge to resp_valid high:
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- req_ready=0 in all states except IDLE. req_valid while busy is ignored; there is no response backpressure.
- Reset mid-operation: strobes drop immediately (asynchronously), so no memory write occurs if reset is asserted before the WRITE posedge. Any pending response is discarded.

Optional Feature:
- MAU_ROM_WRITE_PROTECT_EN
- Defined: any store with req_type=`MEM_ROM is rejected in IDLE -> RESP with resp_error=1. mem_read and mem_write stay 0.
- Undefined: ROM stores proceed like RAM stores.

Test Plan:
- Word load, RAM[3]=32'h80017FFF, addr 0x0C, size 10 -> one mem_read cycle with mem_address=3; resp_valid 2 cycles after accept; resp_rdata=32'h80017FFF; error=0.
- Sub-word loads from the same word:
  - lb 0x0F -> 32'hFFFFFF80
  - lbu 0x0F -> 32'h00000080
  - lh 0x0C -> 32'h00007FFF
  - lh 0x0E -> 32'hFFFF8001
  - lhu 0x0E -> 32'h00008001
- sb 0xAB to 0x0D with RAM[3]=32'h80017FFF -> mem_read 1 cycle, then mem_write 1 cycle with data 32'h8001ABFF; RAM[3]=32'h8001ABFF; resp after 3 cycles.
- Error cases: lh 0x0D, lw 0x0E, lw 0x100 (word 64), size 11 -> resp_error=1 one cycle after accept; resp_rdata=0; no mem strobes.
- Reset asserted mid-cycle in WRITE of sw 32'h12345678 to RAM word 5 -> mem_write falls at once; RAM[5] unchanged; req_ready=1 after release; next request completes normally.
- ROM store sw 32'hDEADBEEF to ROM word 2:
  - macro defined -> error, ROM[2] unchanged
  - macro undefined -> ROM[2]=32'hDEADBEEF
